alu_exec_mc: RTL and testbench
==============================

# alu_exec_mc

Multi-cycle execute unit that consumes the 4-bit ALU control code produced by the ALU decoder and computes the operation on two XLEN-bit operands. It sits in the EX stage between the decode/register-read logic and writeback/branch resolution. Single-cycle operations complete in one cycle. Shifts use a serial 1-bit-per-cycle shifter to save area. A valid/ready handshake on both sides lets the pipeline stall on shifts.

## Interface
- XLEN, 32, operand/result width; SHW = $clog2(XLEN) is derived
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- alu_ctrl  in  4  control code (encodings in Operation)
- op_a  in  XLEN  operand A (rs1)
- op_b  in  XLEN  operand B (rs2 or immediate); shift amount = op_b[SHW-1:0]
- flush  in  1  synchronous abort of in-flight operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  operation result
- zero  out  1  result == 0

## Operation
- Codes:
  - AND 0000, OR 0001: bitwise.
  - ADD 0010, SUB 0110: modulo 2^XLEN, no overflow flag.
  - SRA 0011, SLL 1000, SRL 1001: shifts.
  - SLT 0111, SLTU 1111: result 1/0, signed and unsigned A<B.
  - XOR 1010.
  - GE 1011, GEU 1101: result 1/0, signed and unsigned A>=B.
  - EQ 1110: result 1/0.
- Unlisted codes (0100, 0101, 1100) complete as single-cycle ops with result 0.
- Operands and alu_ctrl are captured on the handshake (in_valid & in_ready). Later input changes have no effect.
- FSM states:
  - IDLE: in_ready=1. On handshake, a non-shift op goes to DONE with the result registered. A shift with shamt=0 goes to DONE with result=op_a. A shift with shamt>0 loads the shift register and count=shamt, then goes to SHIFT.
  - SHIFT: each cycle shift by 1 and decrement count.
    - SLL fills with 0; SRL fills with 0; SRA fills with the captured op_a[XLEN-1].
    - When the shift that makes count reach 0 completes, go to DONE.
  - DONE: out_valid=1; result and zero are stable. On out_ready go to IDLE.
- zero is computed from the registered result and is valid whenever out_valid=1.
- flush has priority over everything except reset. From any state it goes to IDLE next cycle with out_valid=0. A handshake in the same cycle as flush is discarded.
- reset mid-operation behaves like flush and also clears the datapath registers.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, result=0, zero=1.
  - Internal: count=0.

## Timing
- Non-shift op: handshake at edge N, out_valid=1 after edge N+1 (1-cycle latency).
- Shift by k>0: out_valid=1 after edge N+1+k. Shift by 0: same as non-shift.
- Throughput: no back-to-back acceptance. The minimum spacing between handshakes is 2 cycles when out_ready is held high.
- out_valid stays high and result stays constant until the cycle with out_ready=1. The unit returns to IDLE on that edge.
- in_ready is a pure function of state, with no combinational path from in_valid. out_valid has no combinational path from out_ready.

## Structure
- Shared package alu_pkg holds:
  - localparams for the 13 alu_ctrl encodings, shared with the ALU decoder;
  - the FSM state enum (IDLE, SHIFT, DONE).
- One sub-module alu_shift_serial contains:
  - the shift register, count, and direction/arith select;
  - ports load, shamt, data_in, mode[1:0], busy, data_out.
- Single-cycle arithmetic/compare logic stays in alu_exec_mc as combinational logic feeding the result register.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, zero=0, out_valid one cycle after handshake.
- SUB 5-5 -> result 0, zero=1. SLT 0xFFFFFFFF,1 -> 1. SLTU same operands -> 0. GEU same operands -> 1. EQ 7,7 -> 1.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF, out_valid exactly 32 cycles after handshake. SLL 1 by 0 -> 1 after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after a SRL result. Check result and out_valid are held, in_ready=0, and new in_valid is ignored. Then a one-cycle out_ready pulse -> IDLE, in_ready=1.
- flush during SHIFT (SLL by 20, flush at cycle 10) -> out_valid never asserts, in_ready=1 next cycle. Next ADD 2+3 -> 5.
- Assert reset while in DONE -> next cycle out_valid=0, result=0, zero=1, in_ready=1. Undefined code 0100 -> result 0, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-code encodings, shifter modes, execute FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

  // alu_ctrl encodings, also produced by the ALU decoder
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_GE   = 4'b1011;
  localparam logic [3:0] ALU_GEU  = 4'b1101;
  localparam logic [3:0] ALU_EQ   = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // Serial shifter direction / fill select
  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_serial.sv
// Serial 1-bit-per-cycle shifter: loads operand and count, shifts once per cycle until count hits 0.
// Latency: shamt cycles after load; data_out is the value after the current cycle's shift.
// Backpressure: none; the owner loads only when idle and watches last/busy.
module alu_shift_serial
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [SHW-1:0]  shamt,
  input  logic [XLEN-1:0] data_in,
  input  logic [1:0]      mode,
  output logic            busy,
  output logic            last,
  output logic [XLEN-1:0] data_out
);

  logic [XLEN-1:0] r_data;
  logic [SHW-1:0]  r_count;
  logic [1:0]      r_mode;
  logic            r_fill;
  logic [XLEN-1:0] w_step;

  // One-position shift of the held value; SRA fills with the sign captured at load
  always_comb begin
    w_step = r_data;
    case (r_mode)
      SH_SLL:  w_step = {r_data[XLEN-2:0], 1'b0};
      SH_SRL:  w_step = {1'b0, r_data[XLEN-1:1]};
      default: w_step = {r_fill, r_data[XLEN-1:1]};
    endcase
  end

  // Load on request, otherwise shift and count down while work remains
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_count <= '0;
      r_mode  <= SH_SLL;
      r_fill  <= 1'b0;
    end else if (load) begin
      r_data  <= data_in;
      r_count <= shamt;
      r_mode  <= mode;
      r_fill  <= (mode == SH_SRA) & data_in[XLEN-1];
    end else if (r_count != '0) begin
      r_data  <= w_step;
      r_count <= r_count - SHW'(1);
    end
  end

  assign busy     = (r_count != '0);
  assign last     = (r_count == SHW'(1));
  assign data_out = w_step;

endmodule

// File: rtl/alu_exec_mc.sv
// Multi-cycle EX unit: single-cycle logic/arith/compare ops, serial shifts, registered result.
// Latency: 1 cycle for non-shift ops and shift-by-0, 1+shamt cycles for shifts.
// Backpressure: valid/ready both sides; accepts only in IDLE, holds result in DONE until out_ready.
module alu_exec_mc
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_res_d;
  logic            w_res_we;
  logic            w_load;
  logic            w_accept;
  logic            w_is_shift;
  logic [SHW-1:0]  w_shamt;
  logic [1:0]      w_mode;
  logic            w_sh_clr;
  logic            w_sh_busy;
  logic            w_sh_last;
  logic [XLEN-1:0] w_sh_data;

  assign w_accept   = in_valid & in_ready & ~flush;
  assign w_is_shift = is_shift_op(alu_ctrl);
  assign w_shamt    = op_b[SHW-1:0];
  assign w_mode     = (alu_ctrl == ALU_SLL) ? SH_SLL :
                      (alu_ctrl == ALU_SRL) ? SH_SRL : SH_SRA;
  // A flush abandons any shift in progress so the counter is idle on return to IDLE
  assign w_sh_clr   = reset | flush;

  alu_shift_serial #(.XLEN(XLEN), .SHW(SHW)) u_shift (
    .clk      (clk),
    .reset    (w_sh_clr),
    .load     (w_load),
    .shamt    (w_shamt),
    .data_in  (op_a),
    .mode     (w_mode),
    .busy     (w_sh_busy),
    .last     (w_sh_last),
    .data_out (w_sh_data)
  );

  // Single-cycle ops; unlisted codes produce 0
  always_comb begin
    w_alu = '0;
    case (alu_ctrl)
      ALU_AND:  w_alu = op_a & op_b;
      ALU_OR:   w_alu = op_a | op_b;
      ALU_XOR:  w_alu = op_a ^ op_b;
      ALU_ADD:  w_alu = op_a + op_b;
      ALU_SUB:  w_alu = op_a - op_b;
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_GE:   w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) >= $signed(op_b))};
      ALU_GEU:  w_alu = {{(XLEN-1){1'b0}}, (op_a >= op_b)};
      ALU_EQ:   w_alu = {{(XLEN-1){1'b0}}, (op_a == op_b)};
      default:  w_alu = '0;
    endcase
  end

  // Next state, shifter load and result-register write enable; flush overrides all
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_res_we    = 1'b0;
    w_res_d     = w_alu;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_shift && (w_shamt != '0)) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_res_we    = 1'b1;
            w_res_d     = w_is_shift ? op_a : w_alu;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        // Final shift lands in the result register on the same edge the count reaches 0
        if (w_sh_last) begin
          w_res_we    = 1'b1;
          w_res_d     = w_sh_data;
          w_state_nxt = ST_DONE;
        end else if (!w_sh_busy) begin
          // Shifter idle without a final step: nothing to wait for, recover to IDLE
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
      w_res_we    = 1'b0;
    end
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_res_we) r_result <= w_res_d;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = (r_result == '0);

endmodule

// File: tb/tb_alu_exec_mc.sv
// Self-checking bench for alu_exec_mc: vector table plus backpressure, flush and reset sequences.
// Latency: measured in clock edges from the cycle the request is presented.
// Backpressure: exercised by holding out_ready low while offering new requests.
module tb_alu_exec_mc;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_mc #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, drop it after the capture edge, wait (bounded) for out_valid
  task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat);
    int cyc;
    cyc       = 0;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) begin
        in_valid = 1'b0;
        alu_ctrl = ALU_ADD;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h1234_5678;
      end
    end while (!out_valid && cyc < 40);
    check({name, "_lat"}, 32'(cyc), 32'(lat));
    check({name, "_result"}, result, res);
    check({name, "_zero"}, {31'b0, zero}, {31'b0, (res == 32'h0)});
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_rel_in_ready"}, {31'b0, in_ready}, 32'd1);
    check({name, "_rel_out_valid"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"add_ovf",  ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1};
    vecs[1]  = '{"sub_zero", ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1};
    vecs[2]  = '{"slt",      ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
    vecs[3]  = '{"sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[4]  = '{"geu",      ALU_GEU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
    vecs[5]  = '{"eq",       ALU_EQ,   32'h0000_0007, 32'h0000_0007, 32'h0000_0001, 1};
    vecs[6]  = '{"sra31",    ALU_SRA,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 32};
    vecs[7]  = '{"sll0",     ALU_SLL,  32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1};
    vecs[8]  = '{"undef4",   4'b0100,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[9]  = '{"undefC",   4'b1100,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[10] = '{"and",      ALU_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1};
    vecs[11] = '{"or",       ALU_OR,   32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1};
    vecs[12] = '{"xor",      ALU_XOR,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1};
    vecs[13] = '{"ge_neg",   ALU_GE,   32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[14] = '{"srl4",     ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5};
    vecs[15] = '{"sll_mask", ALU_SLL,  32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 5};
    vecs[16] = '{"sra_pos",  ALU_SRA,  32'h4000_0000, 32'h0000_0002, 32'h1000_0000, 3};
    vecs[17] = '{"sra_neg",  ALU_SRA,  32'hF000_0000, 32'h0000_0004, 32'hFF00_0000, 5};
  end

  initial begin
    int seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'b0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_zero",      {31'b0, zero},      32'd1);

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
      release_out(vecs[i].name);
    end

    // Backpressure: result held for 5 cycles while a new request is offered
    run_op("bp_srl", ALU_SRL, 32'h0000_00F0, 32'h0000_0004, 32'h0000_000F, 5);
    in_valid = 1'b1;
    alu_ctrl = ALU_ADD;
    op_a     = 32'd1;
    op_b     = 32'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_result",    result,             32'h0000_000F);
      check("bp_in_ready",  {31'b0, in_ready},  32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");
    tick();
    check("bp_ignored", {31'b0, out_valid}, 32'd0);

    // Flush in the middle of a 20-bit SLL
    alu_ctrl = ALU_SLL;
    op_a     = 32'd1;
    op_b     = 32'd20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    check("fl_busy_in_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_in_ready",  {31'b0, in_ready},  32'd1);
    check("fl_out_valid", {31'b0, out_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("fl_never_valid", 32'(seen), 32'd0);
    run_op("fl_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 1);
    release_out("fl_add");

    // Handshake coincident with flush is discarded
    alu_ctrl = ALU_ADD;
    op_a     = 32'd1;
    op_b     = 32'd1;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flhs_out_valid", {31'b0, out_valid}, 32'd0);
    check("flhs_in_ready",  {31'b0, in_ready},  32'd1);
    tick();
    check("flhs_still_idle", {31'b0, out_valid}, 32'd0);

    // Reset while holding a result in DONE
    run_op("rd_add", ALU_ADD, 32'd9, 32'd1, 32'd10, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rd_out_valid", {31'b0, out_valid}, 32'd0);
    check("rd_result",    result,             32'd0);
    check("rd_zero",      {31'b0, zero},      32'd1);
    check("rd_in_ready",  {31'b0, in_ready},  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
